// File: rtl/freq_div_pkg.sv
// Shared definitions for the frequency divider and its pwm_meter monitor path.
package freq_div_pkg;

    // Default counter width, shared by the divider and the meter.
    localparam int FD_W = 4;

    // Meter FSM: waiting for the first edge, then alternating high/low phase counting.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

endpackage : freq_div_pkg

// File: rtl/edge_detect.sv
// Registers the measured signal and flags its rising and falling edges.
// The input is already synchronous to clk, so there is no synchroniser stage.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic sig_d_q;

    // Previous-cycle copy of sig_in; cleared so the first high sample counts as a rise.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // pre-edge values; blocking here would create order-dependent simulation.
        if (reset) begin
            sig_d_q <= 1'b0;
        end else begin
            sig_d_q <= sig_in;
        end
    end

    assign rise = sig_in & ~sig_d_q;
    assign fall = ~sig_in & sig_d_q;

endmodule : edge_detect

// File: rtl/pwm_meter.sv
// Measures period and high-time of a clk-synchronous pulse train in clock cycles.
// Reports a registered result with a one-cycle valid strobe per completed period,
// plus lock and overflow status. A missing edge for 2^W-1 cycles aborts to IDLE.
module pwm_meter
    import freq_div_pkg::*;
#(
    parameter int W = FD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sig_in,
    output logic [W-1:0] meas_period,
    output logic [W-1:0] meas_high,
    output logic         valid,
    output logic         locked,
    output logic         overflow
);

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic rise;
    logic fall;

    state_e         state_q,       state_d;
    logic [W-1:0]   per_cnt_q,     per_cnt_d;
    logic [W-1:0]   hi_cnt_q,      hi_cnt_d;
    logic [W-1:0]   meas_period_q, meas_period_d;
    logic [W-1:0]   meas_high_q,   meas_high_d;
    logic           valid_q,       valid_d;
    logic           locked_q,      locked_d;
    logic           overflow_q,    overflow_d;

    logic           complete;
    logic           timeout;

    edge_detect u_edge_detect (
        .clk    (clk),
        .reset  (reset),
        .sig_in (sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    // Next-state logic: phase tracking, counting, result capture and timeout.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        per_cnt_d     = per_cnt_q;
        hi_cnt_d      = hi_cnt_q;
        meas_period_d = meas_period_q;
        meas_high_d   = meas_high_q;
        valid_d       = 1'b0;
        locked_d      = locked_q;
        overflow_d    = overflow_q;

        // A rising edge in LOW closes the period; it wins over the timeout so a
        // period of exactly 2^W-1 is still reported.
        complete = (state_q == ST_LOW) && rise;
        timeout  = (state_q != ST_IDLE) && (per_cnt_q == CNT_MAX) && !complete;

        if (timeout) begin
            state_d    = ST_IDLE;
            per_cnt_d  = '0;
            hi_cnt_d   = '0;
            overflow_d = 1'b1;
            locked_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d   = ST_HIGH;
                        per_cnt_d = CNT_ONE;
                        hi_cnt_d  = CNT_ONE;
                    end else begin
                        per_cnt_d = '0;
                        hi_cnt_d  = '0;
                    end
                end
                ST_HIGH: begin
                    per_cnt_d = per_cnt_q + CNT_ONE;
                    if (fall) begin
                        state_d = ST_LOW;
                    end else begin
                        hi_cnt_d = hi_cnt_q + CNT_ONE;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        meas_period_d = per_cnt_q;
                        meas_high_d   = hi_cnt_q;
                        valid_d       = 1'b1;
                        locked_d      = 1'b1;
                        overflow_d    = 1'b0;
                        state_d       = ST_HIGH;
                        per_cnt_d     = CNT_ONE;
                        hi_cnt_d      = CNT_ONE;
                    end else begin
                        per_cnt_d = per_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    per_cnt_d = '0;
                    hi_cnt_d  = '0;
                end
            endcase
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            per_cnt_q     <= '0;
            hi_cnt_q      <= '0;
            meas_period_q <= '0;
            meas_high_q   <= '0;
            valid_q       <= 1'b0;
            locked_q      <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            per_cnt_q     <= per_cnt_d;
            hi_cnt_q      <= hi_cnt_d;
            meas_period_q <= meas_period_d;
            meas_high_q   <= meas_high_d;
            valid_q       <= valid_d;
            locked_q      <= locked_d;
            overflow_q    <= overflow_d;
        end
    end

    assign meas_period = meas_period_q;
    assign meas_high   = meas_high_q;
    assign valid       = valid_q;
    assign locked      = locked_q;
    assign overflow    = overflow_q;

endmodule : pwm_meter

// File: tb/tb_pwm_meter.sv
// Scoreboard bench for pwm_meter. The reference model works from the sampled
// waveform history: a period is the distance between two accepted rising edges,
// the high time is the number of high samples in between, and a measurement is
// abandoned once 2^W-1 cycles pass after the last rise without a new one.
module tb_pwm_meter;

    localparam int W    = 4;
    localparam int PMAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         sig_in;
    logic [W-1:0] meas_period;
    logic [W-1:0] meas_high;
    logic         valid;
    logic         locked;
    logic         overflow;

    pwm_meter #(.W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .sig_in      (sig_in),
        .meas_period (meas_period),
        .meas_high   (meas_high),
        .valid       (valid),
        .locked      (locked),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Count of rising edges seen so far; tags when each expectation becomes visible.
    int unsigned cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic        valid;
        logic        locked;
        logic        overflow;
        logic [W-1:0] mp;
        logic [W-1:0] mh;
    } stat_t;

    typedef struct {
        logic [W-1:0] p;
        logic [W-1:0] h;
    } res_t;

    stat_t stat_q[$];
    res_t  res_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model state.
    bit          m_armed  = 1'b0;
    int unsigned m_p      = 0;
    logic        m_prev   = 1'b0;
    bit          m_hist[$];
    logic        m_locked = 1'b0;
    logic        m_ov     = 1'b0;
    int          m_mp     = 0;
    int          m_mh     = 0;

    // Drive one cycle of stimulus and push the expected state after the next edge.
    task automatic step(input logic s, input logic r);
        int unsigned c;
        bit          rise;
        int          hi;
        stat_t       e;
        res_t        res;
        @(posedge clk);
        #1;
        sig_in = s;
        reset  = r;
        c      = cyc + 1;
        e.valid = 1'b0;
        if (r) begin
            m_armed  = 1'b0;
            m_prev   = 1'b0;
            m_locked = 1'b0;
            m_ov     = 1'b0;
            m_mp     = 0;
            m_mh     = 0;
            m_hist.delete();
        end else begin
            rise = s && !m_prev;
            if (m_armed && rise) begin
                hi = 0;
                foreach (m_hist[i]) hi += int'(m_hist[i]);
                m_mp     = int'(c - m_p);
                m_mh     = hi;
                res.p    = W'(m_mp);
                res.h    = W'(m_mh);
                res_q.push_back(res);
                e.valid  = 1'b1;
                m_locked = 1'b1;
                m_ov     = 1'b0;
                m_p      = c;
                m_hist.delete();
            end else if (m_armed && (c - m_p) == PMAX) begin
                m_ov     = 1'b1;
                m_locked = 1'b0;
                m_armed  = 1'b0;
            end else if (!m_armed && rise) begin
                m_armed = 1'b1;
                m_p     = c;
                m_hist.delete();
            end
            if (m_armed) m_hist.push_back(s);
            m_prev = s;
        end
        e.cyc      = c;
        e.locked   = m_locked;
        e.overflow = m_ov;
        e.mp       = W'(m_mp);
        e.mh       = W'(m_mh);
        stat_q.push_back(e);
    endtask

    task automatic wave(input int h, input int l, input int n);
        repeat (n) begin
            repeat (h) step(1'b1, 1'b0);
            repeat (l) step(1'b0, 1'b0);
        end
    endtask

    task automatic hold(input logic s, input int n);
        repeat (n) step(s, 1'b0);
    endtask

    // Monitor: per-cycle status check, plus result pop whenever the DUT strobes valid.
    always @(negedge clk) begin
        stat_t e;
        res_t  r;
        while (stat_q.size() > 0 && stat_q[0].cyc < cyc) void'(stat_q.pop_front());
        if (stat_q.size() > 0 && stat_q[0].cyc == cyc) begin
            e = stat_q.pop_front();
            check("status{valid,locked,overflow,period,high}",
                  32'({valid, locked, overflow, meas_period, meas_high}),
                  32'({e.valid, e.locked, e.overflow, e.mp, e.mh}));
        end
        if (valid === 1'b1) begin
            if (res_q.size() == 0) begin
                check("unexpected_valid", 32'(valid), 32'(0));
            end else begin
                r = res_q.pop_front();
                check("meas_period", 32'(meas_period), 32'(r.p));
                check("meas_high", 32'(meas_high), 32'(r.h));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h;
        int l;
        reset  = 1'b1;
        sig_in = 1'b0;
        repeat (3) step(1'b0, 1'b1);

        // Steady 2 high / 3 low.
        wave(2, 3, 6);
        // Divider-style loopback: 6/4, then reprogrammed to 3/1.
        wave(4, 2, 5);
        wave(1, 2, 5);
        // Lost signal held low, then recovery with 4/1.
        hold(1'b0, 20);
        wave(1, 3, 4);
        // Period exactly 2^W-1, then 2^W.
        wave(1, 14, 3);
        wave(1, 15, 3);
        // Alternating single-cycle high/low.
        wave(1, 1, 8);
        // Reset in the middle of a high phase.
        wave(3, 3, 2);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        wave(2, 2, 4);
        // 100 % duty.
        hold(1'b1, 20);
        hold(1'b0, 3);

        // Randomized periods, including ones long enough to time out, and stray resets.
        for (int i = 0; i < 300; i++) begin
            h = int'($urandom_range(1, 9));
            l = int'($urandom_range(1, 9));
            if ($urandom_range(0, 24) == 0) h = int'($urandom_range(10, 18));
            for (int j = 0; j < h; j++) step(1'b1, ($urandom_range(0, 199) == 0));
            for (int j = 0; j < l; j++) step(1'b0, ($urandom_range(0, 199) == 0));
        end

        hold(1'b0, 20);
        @(negedge clk);
        @(negedge clk);
        check("pending_results", 32'(res_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pwm_meter
